// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: depth helper and Gray/binary conversions for pointers up to 32 bits
package async_fifo_pkg;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  // Zero-extended inputs convert correctly, so callers cast to their pointer width
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer into the clk domain
module sync_2ff #(
  parameter int WIDTH = 1
)(
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk) begin
    meta <= d;
    q <= meta;
  end
endmodule

// File: rtl/async_fifo_cdc.sv
// async_fifo_cdc: dual-clock FIFO with Gray-coded pointer crossing and per-domain reset sync
module async_fifo_cdc
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RESERVE    = 0
)(
  input  logic                  wr_clk,
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  has_data
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FULL_AT = PW'(DEPTH - RESERVE);
  logic wr_rst, rd_rst, wr_go, rd_go;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wbin, wgray, wbin_next, rgray_sync, rbin_sync;
  logic [PW-1:0] rbin, rgray, rbin_next, wgray_sync, wbin_sync;
  sync_2ff #(.WIDTH(1))  u_wr_rst (.clk(wr_clk), .d(rst),   .q(wr_rst));
  sync_2ff #(.WIDTH(1))  u_rd_rst (.clk(rd_clk), .d(rst),   .q(rd_rst));
  sync_2ff #(.WIDTH(PW)) u_rptr   (.clk(wr_clk), .d(rgray), .q(rgray_sync));
  sync_2ff #(.WIDTH(PW)) u_wptr   (.clk(rd_clk), .d(wgray), .q(wgray_sync));
  assign wr_go = wr_en & ~full;
  assign wbin_next = wbin + PW'(wr_go);
  assign rbin_sync = PW'(gray2bin(32'(rgray_sync)));
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin <= '0;
      wgray <= '0;
      full <= 1'b1;
    end else begin
      wbin <= wbin_next;
      wgray <= PW'(bin2gray(32'(wbin_next)));
      full <= (wbin_next - rbin_sync) >= FULL_AT;
    end
  end
  always_ff @(posedge wr_clk) begin
    if (wr_go) mem[wbin[ADDR_WIDTH-1:0]] <= wr_data;
  end
  assign rd_go = rd_en & ~empty;
  assign rbin_next = rbin + PW'(rd_go);
  assign wbin_sync = PW'(gray2bin(32'(wgray_sync)));
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rbin <= '0;
      rgray <= '0;
      empty <= 1'b1;
      rd_data <= '0;
    end else begin
      rbin <= rbin_next;
      rgray <= PW'(bin2gray(32'(rbin_next)));
      empty <= rbin_next == wbin_sync;
      if (rd_go) rd_data <= mem[rbin[ADDR_WIDTH-1:0]];
    end
  end
  assign has_data = ~empty;
endmodule

// File: tb/tb_async_fifo_cdc.sv
// tb_async_fifo_cdc: scoreboard bench for async_fifo_cdc (RESERVE=0 main instance, RESERVE=2 side instance)
module tb_async_fifo_cdc;
  logic wr_clk = 0, rd_clk = 0, rst = 1;
  logic wr_en = 0, rd_en = 0, full, empty, has_data;
  logic [7:0] wr_data = 0, rd_data;
  logic r2_wr_en = 0, r2_rd_en = 0, r2_full, r2_empty, r2_has_data;
  logic [7:0] r2_wr_data = 0, r2_rd_data;
  int checks = 0, errors = 0, push_cnt = 0, acc_cnt = 0, full_seen = 0, empty_seen = 0;
  logic [7:0] sb[$];
  logic [15:0] wl = 16'hACE1, rl = 16'h1D2B;

  async_fifo_cdc #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESERVE(0)) u_dut (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .has_data(has_data));
  async_fifo_cdc #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESERVE(2)) u_res (
    .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst), .wr_en(r2_wr_en), .wr_data(r2_wr_data), .full(r2_full),
    .rd_en(r2_rd_en), .rd_data(r2_rd_data), .empty(r2_empty), .has_data(r2_has_data));

  always #10 wr_clk = ~wr_clk;
  always begin
    #10 rd_clk = 1;
    #11 rd_clk = 0;
  end

  function automatic logic [15:0] lfsr(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard producer: accepted writes, sampled mid-cycle
  always @(negedge wr_clk) begin
    if (wr_en && !full) begin
      sb.push_back(wr_data);
      push_cnt++;
    end
    if (full) full_seen++;
  end

  // Monitor: an accepted read presents its word right after the next rd_clk edge
  always @(negedge rd_clk) begin
    if (empty) empty_seen++;
    if (rd_en && !empty) begin
      acc_cnt++;
      @(posedge rd_clk);
      #1;
      if (sb.size() == 0) chk("underflow", 1, 0);
      else chk("rd_data", rd_data, sb.pop_front());
    end
  end

  task automatic run_phase(input int pw, input int pr, input int n, input bit mt);
    int wt, rt;
    wt = push_cnt + n;
    rt = acc_cnt + n;
    full_seen = 0;
    empty_seen = 0;
    fork
      begin
        int g = 0;
        while (push_cnt < wt && g < 40 * n) begin
          @(posedge wr_clk); #1;
          g++;
          if (push_cnt >= wt) break;
          wl = lfsr(wl);
          wr_en = mt ? !full : (wl < pw);
          wr_data = 8'($urandom);
        end
        wr_en = 0;
      end
      begin
        int g = 0;
        while (acc_cnt < rt && g < 40 * n) begin
          @(posedge rd_clk); #1;
          g++;
          if (acc_cnt >= rt) break;
          rl = lfsr(rl);
          rd_en = mt ? !empty : (rl < pr);
        end
        rd_en = 0;
      end
    join
    repeat (3) @(posedge rd_clk);
    #1;
    chk("words_written", push_cnt >= wt, 1);
    chk("words_read", acc_cnt >= rt, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g;
    repeat (20) @(posedge wr_clk);
    #1;
    chk("rst_full", full, 1);
    chk("rst_empty", empty, 1);
    chk("rst_has_data", has_data, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_rst", u_dut.wr_rst, 1);
    chk("rst_rd_rst", u_dut.rd_rst, 1);
    rst = 0;
    fork
      begin
        repeat (3) @(posedge wr_clk);
        #1;
        chk("rel_wr_rst", u_dut.wr_rst, 0);
        chk("rel_full", full, 0);
        chk("rel_r2_full", r2_full, 0);
      end
      begin
        repeat (3) @(posedge rd_clk);
        #1;
        chk("rel_rd_rst", u_dut.rd_rst, 0);
        chk("rel_empty", empty, 1);
        chk("rel_has_data", has_data, 0);
      end
    join
    // Fill to 16 with no reads, then one ignored write
    for (int i = 0; i < 16; i++) begin
      @(posedge wr_clk); #1;
      if (i == 15) chk("full_at_15", full, 0);
      wr_en = 1;
      wr_data = 8'(i);
    end
    @(posedge wr_clk); #1;
    chk("full_at_16", full, 1);
    wr_data = 8'hAA;
    @(posedge wr_clk); #1;
    wr_en = 0;
    chk("full_after_17th", full, 1);
    chk("pushes_16", sb.size(), 16);
    g = 0;
    while (empty && g < 20) begin @(posedge rd_clk); #1; g++; end
    chk("fill_visible", has_data, 1);
    base = acc_cnt;
    rd_en = 1;
    g = 0;
    while (acc_cnt < base + 16 && g < 60) begin @(posedge rd_clk); #1; g++; end
    repeat (4) @(posedge rd_clk);
    #1;
    rd_en = 0;
    chk("drain_count", acc_cnt - base, 16);
    chk("drain_empty", empty, 1);
    chk("drain_has_data", has_data, 0);
    chk("rd_data_hold", rd_data, 8'h0F);
    run_phase(32768, 32768, 5000, 0);
    run_phase(52429, 32768, 5000, 0);
    chk("wh_full_seen", full_seen > 0, 1);
    run_phase(32768, 52429, 5000, 0);
    chk("rh_empty_seen", empty_seen > 0, 1);
    run_phase(0, 0, 5000, 1);
    // Reset with data in flight discards it
    for (int i = 0; i < 5; i++) begin
      @(posedge wr_clk); #1;
      wr_en = 1;
      wr_data = 8'hC0 + 8'(i);
    end
    @(posedge wr_clk); #1;
    wr_en = 0;
    repeat (6) @(posedge wr_clk);
    #1;
    chk("mid_has_data", has_data, 1);
    rst = 1;
    repeat (4) @(posedge wr_clk);
    #1;
    sb.delete();
    rst = 0;
    repeat (6) @(posedge wr_clk);
    #1;
    chk("mid_empty", empty, 1);
    chk("mid_has_data_clr", has_data, 0);
    chk("mid_full", full, 0);
    chk("mid_rd_data", rd_data, 0);
    run_phase(32768, 32768, 50, 0);
    // RESERVE=2 instance: full at 14 words, clears after one read
    for (int i = 0; i < 14; i++) begin
      @(posedge wr_clk); #1;
      if (i == 13) chk("r2_full_at_13", r2_full, 0);
      r2_wr_en = 1;
      r2_wr_data = 8'h50 + 8'(i);
    end
    @(posedge wr_clk); #1;
    r2_wr_en = 0;
    chk("r2_full_at_14", r2_full, 1);
    g = 0;
    while (r2_empty && g < 20) begin @(posedge rd_clk); #1; g++; end
    chk("r2_visible", r2_has_data, 1);
    r2_rd_en = 1;
    @(posedge rd_clk); #1;
    r2_rd_en = 0;
    chk("r2_rd_data", r2_rd_data, 8'h50);
    g = 0;
    while (r2_full && g < 3) begin @(posedge wr_clk); #1; g++; end
    chk("r2_full_clear", r2_full, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
